// File: rtl/stage_if.sv
// Instruction fetch stage: holds the fetch PC, issues one outstanding
// instruction-memory request at a time and hands words to decode through a one-entry skid buffer.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_dest,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] next_pc,
    output logic        instr_valid,
    output logic [31:0] debug_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = branch_dest & ~32'h3;
    assign debug_pc    = pc;

    // imem_addr is a register: in FETCH it tracks pc, in FLUSH it keeps the
    // killed request's address, so it doubles as the latched flush address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b1;
            imem_addr   <= RESET_PC;
            instr       <= 32'h0;
            next_pc     <= 32'h0;
            instr_valid <= 1'b0;
            buf_instr   <= 32'h0;
            buf_pc      <= 32'h0;
        end else if (branch_taken) begin
            pc       <= redirect_pc;
            imem_req <= 1'b1;
            if (!stall) begin
                instr       <= 32'h0;
                instr_valid <= 1'b0;
            end
            case (state)
                FETCH: begin
                    if (imem_ack) imem_addr <= redirect_pc;
                    else          state     <= FLUSH;
                end
                FULL: begin
                    state     <= FETCH;
                    imem_addr <= redirect_pc;
                end
                FLUSH: begin
                    // A killed request completing alongside a new redirect ends the drain.
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_addr <= redirect_pc;
                    end
                end
                default: begin
                    state     <= FETCH;
                    imem_addr <= redirect_pc;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc        <= pc_plus4;
                        imem_addr <= pc_plus4;
                        if (stall) begin
                            buf_instr <= imem_data;
                            buf_pc    <= pc_plus4;
                            imem_req  <= 1'b0;
                            state     <= FULL;
                        end else begin
                            instr       <= imem_data;
                            next_pc     <= pc_plus4;
                            instr_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr       <= 32'h0;
                        instr_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        instr       <= buf_instr;
                        next_pc     <= buf_pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        instr       <= 32'h0;
                        instr_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed fetch scenarios plus a randomized run against a
// program-order stream model, with a memory responder of variable latency.
module tb_stage_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_dest;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        instr_valid;
    logic [31:0] debug_pc;

    int n_vec  = 0;
    int n_fail = 0;

    stage_if #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_dest (branch_dest),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .next_pc     (next_pc),
        .instr_valid (instr_valid),
        .debug_pc    (debug_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: updates 1 time unit after each rising edge.
    bit mem_fixed = 1'b1;
    int mem_lat   = 0;
    bit spur_en   = 1'b0;
    bit mem_busy  = 1'b0;
    int mem_wait  = 0;

    initial begin
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req === 1'b1) begin
                if (!mem_busy || imem_ack) begin
                    mem_wait = mem_fixed ? mem_lat : int'($urandom_range(0, 3));
                    mem_busy = 1'b1;
                end else if (mem_wait > 0) begin
                    mem_wait--;
                end
                imem_ack  = (mem_wait == 0);
                imem_data = mem_word(imem_addr);
            end else begin
                mem_busy  = 1'b0;
                imem_ack  = spur_en && ($urandom_range(0, 3) == 0);
                imem_data = $urandom;
            end
        end
    end

    // Scoreboard: exp_q holds the upcoming program-order stream {instr, next_pc}.
    logic [63:0] exp_q[$];
    logic [31:0] want;
    bit          rst_seen  = 1'b0;
    bit          have_prev = 1'b0;
    int          quiet_cnt = 0;
    logic        p_rst, p_stall, p_req, p_ack, p_valid;
    logic [31:0] p_addr, p_instr, p_next;

    initial begin
        logic [63:0] item;
        bit          consumed;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                if (p_rst) begin
                    check("reset_instr_valid", instr_valid, 1'b0);
                    check("reset_instr", instr, 32'h0);
                    check("reset_next_pc", next_pc, 32'h0);
                end else if (p_stall) begin
                    check("stall_hold_valid", instr_valid, p_valid);
                    check("stall_hold_instr", instr, p_instr);
                    check("stall_hold_next_pc", next_pc, p_next);
                end
                if (!p_rst && p_req && !p_ack) begin
                    check("req_stable", imem_req, 1'b1);
                    check("addr_stable", imem_addr, p_addr);
                end
                if (instr_valid === 1'b0) check("bubble_instr_zero", instr, 32'h0);
            end
            consumed = 1'b0;
            if (rst) begin
                exp_q.delete();
                want      = RESET_PC;
                rst_seen  = 1'b1;
                quiet_cnt = 0;
            end else if (rst_seen) begin
                if (instr_valid && !stall && exp_q.size() > 0) begin
                    consumed = 1'b1;
                    item = exp_q.pop_front();
                    check("stream_next_pc", next_pc, item[31:0]);
                    check("stream_instr", instr, item[63:32]);
                end
                if (branch_taken) begin
                    if (instr_valid && stall && exp_q.size() > 0) begin
                        item = exp_q[0];
                        exp_q.delete();
                        exp_q.push_back(item);
                    end else begin
                        exp_q.delete();
                    end
                    want = branch_dest & ~32'h3;
                end
                if (consumed || stall || branch_taken) quiet_cnt = 0;
                else quiet_cnt++;
                if (quiet_cnt > 12) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL liveness: got %0d idle cycles, expected at most 12", quiet_cnt);
                    quiet_cnt = 0;
                end
            end
            while (rst_seen && exp_q.size() < 2) begin
                exp_q.push_back({mem_word(want), want + 32'd4});
                want = want + 32'd4;
            end
            p_rst     = rst;
            p_stall   = stall;
            p_req     = imem_req;
            p_ack     = imem_ack;
            p_addr    = imem_addr;
            p_valid   = instr_valid;
            p_instr   = instr;
            p_next    = next_pc;
            have_prev = rst_seen;
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_branch(input logic [31:0] dest);
        branch_taken = 1'b1;
        branch_dest  = dest;
        step();
        branch_taken = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] a, input bit need_wait, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (imem_req && imem_addr == a && (!need_wait || !imem_ack)) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (instr_valid) ok = 1'b1;
            else step();
        end
    endtask

    initial begin
        bit ok;
        rst          = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_dest  = 32'h0;
        repeat (3) step();
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_imem_req", imem_req, 1'b1);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_debug_pc", debug_pc, RESET_PC);

        // Zero-wait memory, no stall: one instruction per cycle.
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("zw_valid", instr_valid, 1'b1);
            check("zw_next_pc", next_pc, 32'(4 * k));
            check("zw_instr", instr, mem_word(32'(4 * (k - 1))));
        end

        // Stall while the word at 0x10 is acknowledged.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_req_low", imem_req, 1'b0);
            check("stall_next_pc", next_pc, 32'h10);
            check("stall_instr", instr, mem_word(32'hC));
        end
        stall = 1'b0;
        step();
        check("release_next_pc", next_pc, 32'h14);
        check("release_instr", instr, mem_word(32'h10));
        check("release_req", imem_req, 1'b1);
        check("release_addr", imem_addr, 32'h14);

        // Redirect during the wait cycle of a 2-cycle fetch of 0x20.
        mem_lat = 1;
        pulse_branch(32'h20);
        wait_req(32'h20, 1'b1, ok);
        check("wait_fetch_20", ok, 1'b1);
        pulse_branch(32'h100);
        check("flush_req", imem_req, 1'b1);
        check("flush_addr_held", imem_addr, 32'h20);
        check("flush_bubble", instr_valid, 1'b0);
        step();
        check("after_flush_addr", imem_addr, 32'h100);
        wait_valid(ok);
        check("wait_valid_104", ok, 1'b1);
        check("redirect_next_pc", next_pc, 32'h104);
        check("redirect_instr", instr, mem_word(32'h100));

        // Unaligned redirect target.
        mem_lat = 0;
        pulse_branch(32'h203);
        check("align_debug_pc", debug_pc, 32'h200);
        wait_req(32'h200, 1'b0, ok);
        check("align_req_200", ok, 1'b1);
        wait_valid(ok);
        check("align_valid", ok, 1'b1);
        check("align_next_pc", next_pc, 32'h204);

        // PC wrap at the top of the address space.
        pulse_branch(32'hFFFF_FFFC);
        wait_valid(ok);
        check("wrap_valid", ok, 1'b1);
        check("wrap_next_pc", next_pc, 32'h0);
        check("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
        check("wrap_req_addr", imem_addr, 32'h0);

        // Reset in the middle of a wait.
        mem_lat = 3;
        pulse_branch(32'h40);
        wait_req(32'h40, 1'b1, ok);
        check("wait_fetch_40", ok, 1'b1);
        rst = 1'b1;
        step();
        check("midrst_addr", imem_addr, RESET_PC);
        check("midrst_req", imem_req, 1'b1);
        check("midrst_valid", instr_valid, 1'b0);
        rst = 1'b0;
        step();
        check("postrst_req", imem_req, 1'b1);
        check("postrst_addr", imem_addr, RESET_PC);

        // Randomized traffic.
        mem_fixed = 1'b0;
        spur_en   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       branch_dest = $urandom;
                1:       branch_dest = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2:       branch_dest = 32'($urandom_range(0, 255));
                default: branch_dest = 32'h0000_1000;
            endcase
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst          = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  in  1  downstream decode stage holding; ID outputs must not change.
REQ-005 SHALL have port branch_taken  in  1  one-cycle redirect pulse from execute stage.
REQ-006 SHALL have port branch_dest  in  32  redirect target PC.
REQ-007 SHALL have port imem_req  out  1  instruction memory request.
REQ-008 SHALL have port imem_addr  out  32  word address of request.
REQ-009 SHALL have port imem_ack  in  1  memory completion; imem_data valid same cycle.
REQ-010 SHALL have port imem_data  in  32  fetched instruction.
REQ-011 SHALL have port instr  out  32  registered instruction to decode stage.
REQ-012 SHALL have port next_pc  out  32  registered address of instr plus 4.
REQ-013 SHALL have port instr_valid  out  1  registered; 0 means instr is a bubble.
REQ-014 SHALL have port debug_pc  out  32  current fetch PC.

Function
REQ-015 SHALL keep a 32-bit fetch PC; increments are +4 modulo 2^32, with wrap from 32'hFFFF_FFFC to 0.
REQ-016 SHALL implement three states: FETCH (request outstanding), FULL (one fetched word buffered), FLUSH (draining a killed request).
REQ-017 SHALL drive imem_req=1 in FETCH and FLUSH, 0 in FULL.
REQ-018 SHALL drive imem_addr=PC in FETCH and the latched killed-request address in FLUSH.
REQ-019 SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ack=1 is sampled; imem_ack while imem_req=0 SHALL be ignored.
REQ-020 Transition FETCH, ack, no redirect, !stall: instr<=imem_data, next_pc<=PC+4, instr_valid<=1, PC<=PC+4; stay FETCH. Back-to-back single-cycle acks SHALL give one instruction per cycle.
REQ-021 Transition FETCH, ack, no redirect, stall: buffer<=imem_data, buffer_pc<=PC+4, PC<=PC+4; go to FULL; outputs hold.
REQ-022 Transition FETCH, no ack, !stall: instr<=32'h0, instr_valid<=0; next_pc holds.
REQ-023 Transition FULL, !stall: instr<=buffer, next_pc<=buffer_pc, instr_valid<=1; go to FETCH. FULL with stall holds everything.
REQ-024 SHALL never modify instr, next_pc or instr_valid while stall=1, including on redirect.
REQ-025 branch_taken SHALL have highest priority: PC<=branch_dest with bits [1:0] forced to 0, and any buffered word is discarded.
REQ-026 Redirect while !stall SHALL load bubble outputs (instr=0, instr_valid=0).
REQ-027 Redirect in FETCH with imem_ack=0 SHALL latch the current imem_addr and go to FLUSH; with imem_ack=1 the data SHALL be dropped and the state stays FETCH.
REQ-028 Redirect in FULL SHALL go to FETCH.
REQ-029 Redirect in FLUSH SHALL update PC and remain in FLUSH.
REQ-030 FLUSH SHALL drop the data on ack and go to FETCH using the new PC the next cycle; no instruction from a killed request ever reaches instr.
REQ-031 debug_pc SHALL equal PC combinationally.

Reset
REQ-032 On rst: PC=RESET_PC, state=FETCH, instr=0, next_pc=0, instr_valid=0, buffer cleared. A pending request SHALL be abandoned without draining.
REQ-033 rst SHALL override stall and branch_taken; imem_req=1 with imem_addr=RESET_PC on the first cycle after rst deasserts.

Verification
REQ-034 Zero-wait memory, no stall, reset then 4 cycles -> instr_valid=1 with next_pc 4,8,12,16 and matching data.
REQ-035 Ack at PC=0x10 with stall=1 for 3 cycles -> imem_req=0 during the stall, outputs unchanged; the cycle after release next_pc=0x14; the following request goes to 0x14.
REQ-036 2-cycle-latency memory, branch_taken to 0x100 in the first wait cycle of fetch 0x20 -> imem_addr stays 0x20 until ack, data dropped, next request to 0x100, next valid output has next_pc=0x104.
REQ-037 branch_dest=0x203 -> fetch issued at 0x200.
REQ-038 PC=0xFFFFFFFC, ack -> next_pc=0, next request to 0x0.
REQ-039 rst asserted mid-wait at 0x40 -> next cycle imem_addr=RESET_PC, instr_valid=0.
